// File: rtl/cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_rr_arbiter
//  Purpose  : Round-robin arbiter that shares one CBus memory port between
//             NUM_INPUTS CBus masters (ireqs[0] = ICache, ireqs[1] = DCache).
//             One master is granted per transaction. The grant is held for the
//             whole burst, until the beat carrying ready && last. After that,
//             the arbiter spends one IDLE cycle before it grants again, so a
//             streaming master cannot starve the others.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   asynchronous, active-low reset
//    ireqs      in   [NUM_INPUTS][114] requests from masters
//    iresps     out  [NUM_INPUTS][66]  responses routed back to masters
//    oreq       out  [114]             request towards memory
//    oresp      in   [66]              response from memory
//    busy       out                    high while a transaction is granted
//    grant_idx  out  [IDX_W]           current or most recent grantee
// ----------------------------------------------------------------------------
//  Packed CBus layouts
//    request  [113] valid | [112] is_write | [111:104] len (beats-1)
//             [103:72] addr | [71:64] strobe | [63:0] data
//    response [65] ready | [64] last | [63:0] data
// ============================================================================
module cbus_rr_arbiter #(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_INPUTS-1:0][113:0] ireqs,
    output logic [NUM_INPUTS-1:0][65:0]  iresps,
    output logic [113:0]                 oreq,
    input  logic [65:0]                  oresp,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx
);

    localparam int C_REQ_VALID_BIT  = 113;
    localparam int C_RESP_READY_BIT = 65;
    localparam int C_RESP_LAST_BIT  = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_nxt;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_last_grant_nxt;

    logic [NUM_INPUTS-1:0] w_valid;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_any_valid;
    logic                  w_done;

    // ------------------------------------------------------------------------
    // Valid bits of all masters
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
            assign w_valid[gi] = ireqs[gi][C_REQ_VALID_BIT];
        end
    endgenerate

    // The burst ends on the beat where memory is ready and flags last.
    // A single-beat transfer has last together with its only ready.
    assign w_done = oresp[C_RESP_READY_BIT] & oresp[C_RESP_LAST_BIT];

    // ------------------------------------------------------------------------
    // Round-robin selection. The scan starts at last_grant+1 and wraps modulo
    // NUM_INPUTS. The loop runs from the farthest offset down to the nearest
    // one, so the nearest valid requester writes w_pick last and wins. This
    // logic depends only on the valid bits and last_grant, never on oresp.
    // ------------------------------------------------------------------------
    always_comb begin
        int cand;
        cand        = 0;
        w_pick      = '0;
        w_any_valid = 1'b0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            cand = (int'(r_last_grant) + k) % NUM_INPUTS;
            if (w_valid[cand]) begin
                w_pick      = IDX_W'(cand);
                w_any_valid = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_index_nxt      = r_index;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_index_nxt = w_pick;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Other masters are ignored here. They keep valid asserted, so
                // the next IDLE pass still sees their requests. If the granted
                // master drops valid, the arbiter keeps waiting for last.
                if (w_done) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = r_index;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. After reset, last_grant points at the highest port, so
    // port 0 wins the first contention.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_last_grant <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath routing. Both directions are combinational while BUSY, so
    // request fields track the master and responses see no added latency.
    // Every output here is gated by the registered state, so an asynchronous
    // reset stops forwarding immediately and no response leaks to a master.
    // ------------------------------------------------------------------------
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (r_state == BUSY) begin
            for (int j = 0; j < NUM_INPUTS; j++) begin
                if (IDX_W'(j) == r_index) begin
                    oreq      = ireqs[j];
                    iresps[j] = oresp;
                end
            end
        end
    end

    assign busy      = (r_state == BUSY);
    assign grant_idx = r_index;

endmodule
`default_nettype wire

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Round-robin arbiter that shares the single CBus memory port between the instruction and data caches, or between any NUM_INPUTS CBus masters. It sits between the cache CBus masters (ireqs[0] = ICache, ireqs[1] = DCache) and the top-level oreq/oresp port. It grants one requester per transaction and holds that grant for the whole burst, until the last beat is handshaked. Grant rotates fairly, so a streaming DCache cannot starve instruction refill.

## Interface
- NUM_INPUTS, default 2: number of CBus masters (2..8).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- ireqs  in  cbus_req_t[NUM_INPUTS]  requests from masters; index 0 has first priority after reset.
- iresps  out  cbus_resp_t[NUM_INPUTS]  responses routed back to masters.
- oreq  out  cbus_req_t  request to memory side.
- oresp  in  cbus_resp_t  response from memory side (ready, last, data).
- busy  out  1  high while a transaction is granted.
- grant_idx  out  $clog2(NUM_INPUTS) (min 1)  index of the current or most recent grantee.

## Operation
- Two states: IDLE and BUSY. Registered state, `index` (current grantee) and `last_grant` (previous grantee).
- IDLE:
  - oreq = '0 (valid=0); all iresps = '0.
  - If any ireqs[i].valid, pick the first valid i scanning from last_grant+1 upward, modulo NUM_INPUTS.
  - Next edge: index <= i, state <= BUSY.
  - If no request is valid, stay in IDLE.
- BUSY:
  - oreq = ireqs[index], a combinational pass-through, so address, strobe, data and len track the master.
  - iresps[index] = oresp; every other iresps[j] = '0 (ready=0, last=0).
  - On oresp.ready && oresp.last: state <= IDLE, last_grant <= index.
  - Requests arriving on other ports are ignored until return to IDLE. They are not lost, because masters hold valid.
- Masters must hold valid and request fields stable until their last beat. A master dropping valid mid-burst is a protocol violation: the arbiter stays in BUSY, forwards valid=0, and still waits for oresp.last.
- Single-beat transactions (len=0) complete on the first ready, since last accompanies ready.
- busy = (state==BUSY). grant_idx = index.
- Selection logic is purely combinational over valid bits and last_grant. It must not depend on oresp.

## Timing
- Reset values: state=IDLE, index=0, last_grant=NUM_INPUTS-1 (port 0 wins the first contention), busy=0, grant_idx=0, oreq='0, iresps all '0.
- Reset asserted mid-burst: outputs drop to reset values asynchronously. No response leaks to any master after assertion.
- Grant latency: request valid in cycle t while IDLE -> oreq.valid in cycle t+1.
- Turnaround: last handshake at cycle k -> IDLE at k+1 (no forwarding) -> next oreq.valid at k+2. This gives exactly one dead cycle between back-to-back transactions.
- oresp is routed in the same cycle, with no added latency on data/ready/last.
- Simultaneous requests in IDLE: the round-robin order decides; the loser is granted on the next IDLE pass.
- Wrap-around: last_grant=NUM_INPUTS-1 scans from 0.
- A request that appears in the same cycle as the last handshake is seen in the following IDLE cycle, not earlier.

## Test plan
- Reset then ireqs[0] alone: 4-beat read (len=3), addr 0x8000_0000. Required: oreq.valid from cycle 1, iresps[0] gets 4 ready beats with last on the 4th, iresps[1] stays 0, busy falls 1 cycle after last.
- Both ports valid from reset: port 0 granted first. After port 0's last, one idle cycle follows, then port 1 is granted (oreq.addr switches to the DCache address). A third round with both valid grants port 0 again.
- DCache streaming back-to-back single-beat writes (strobe 0xFF) while ICache requests continuously: grants alternate 1,0,1,0. No port gets two consecutive grants while the other is waiting.
- Port 1 write in BUSY while port 0 raises valid mid-burst: port 0 sees ready=0 throughout. oreq fields equal ireqs[1] every cycle until last.
- Assert reset low in the 2nd beat of an 8-beat burst: busy=0 and oreq.valid=0 in the same cycle. After release, port 0 wins the first contention.
- NUM_INPUTS=3, all valid, each transaction single-beat: grant_idx sequence is 0,1,2,0,1,2.
